// File: rtl/washer_prog_seq.sv
// Washing-machine program sequencer.
// Runs fill / agitate / drain / spin phase chains for four selectable programs,
// timed by an internal seconds prescaler, with e-stop lockout and a done alarm.
// All panel-facing outputs are decoded from the state register only.
module washer_prog_seq #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int CNT_W     = 8,
    parameter int CYC_W     = 4,
    parameter int FILL_SEC  = 60,
    parameter int RUN_SEC   = 60,
    parameter int PAUSE_SEC = 5,
    parameter int DRAIN_SEC = 60,
    parameter int SPIN_SEC  = 60,
    parameter int WASH_CYC  = 7,
    parameter int RINSE_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode_sel,
    input  logic             estop,
    output logic             motor_fwd,
    output logic             motor_rev,
    output logic             inlet,
    output logic             drain,
    output logic             spin,
    output logic             led_stop,
    output logic             alarm,
    output logic             busy,
    output logic [3:0]       phase,
    output logic [CYC_W-1:0] cyc_left
);

    // Prescaler needs to count 0 .. TICK_DIV-1.
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_SEC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_SEC - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_SEC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_SEC - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_SEC - 1);
    localparam logic [CYC_W-1:0] WASH_LD    = CYC_W'(WASH_CYC);
    localparam logic [CYC_W-1:0] RINSE_LD   = CYC_W'(RINSE_CYC);

    // Program codes as presented on mode_sel.
    localparam logic [1:0] MODE_WASH  = 2'd0;
    localparam logic [1:0] MODE_RINSE = 2'd1;
    localparam logic [1:0] MODE_FULL  = 2'd2;
    localparam logic [1:0] MODE_SPIN  = 2'd3;

    // State codes double as the phase output value.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_FWD    = 4'd2,
        S_PAUSE1 = 4'd3,
        S_REV    = 4'd4,
        S_PAUSE2 = 4'd5,
        S_DRAIN  = 4'd6,
        S_SPIN   = 4'd7,
        S_DONE   = 4'd8,
        S_ESTOP  = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic               start_q;
    logic [1:0]         mode_q, mode_d;
    logic               pass_q, pass_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   sec_q, sec_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;

    logic               startEdge;
    logic               tick;
    logic [CNT_W-1:0]   secLast;
    logic [CYC_W-1:0]   cycDec;

    assign startEdge = start & ~start_q;
    assign tick      = (presc_q == PRE_LAST);
    assign cycDec    = cyc_q - 1'b1;

    // Pick the last seconds count of the current timed state.
    always_comb begin
        secLast = '0;
        case (state_q)
            S_FILL:             secLast = FILL_LAST;
            S_FWD, S_REV:       secLast = RUN_LAST;
            S_PAUSE1, S_PAUSE2: secLast = PAUSE_LAST;
            S_DRAIN:            secLast = DRAIN_LAST;
            S_SPIN:             secLast = SPIN_LAST;
            default:            secLast = '0;
        endcase
    end

    // State register plus the sequencing datapath it steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            mode_q  <= MODE_WASH;
            pass_q  <= 1'b0;
            presc_q <= '0;
            sec_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            mode_q  <= mode_d;
            pass_q  <= pass_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic: e-stop first, then start acceptance, then tick-driven phase changes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pass_d  = pass_q;
        sec_d   = sec_q;
        cyc_d   = cyc_q;
        presc_d = tick ? '0 : presc_q + 1'b1;

        if (estop && (state_q != S_IDLE)) begin
            state_d = S_ESTOP;
            pass_d  = 1'b0;
            sec_d   = '0;
            cyc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (startEdge && !estop) begin
                        mode_d  = mode_sel;
                        pass_d  = 1'b0;
                        presc_d = '0;
                        sec_d   = '0;
                        cyc_d   = (mode_sel == MODE_RINSE) ? RINSE_LD : WASH_LD;
                        state_d = (mode_sel == MODE_SPIN) ? S_DRAIN : S_FILL;
                    end
                end

                S_ESTOP: begin
                    if (!estop && !start) begin
                        state_d = S_IDLE;
                    end
                end

                S_FILL, S_FWD, S_PAUSE1, S_REV, S_PAUSE2, S_DRAIN, S_SPIN: begin
                    if (tick) begin
                        if (sec_q == secLast) begin
                            sec_d = '0;
                            case (state_q)
                                S_FILL:   state_d = S_FWD;
                                S_FWD:    state_d = S_PAUSE1;
                                S_PAUSE1: state_d = S_REV;
                                S_REV:    state_d = S_PAUSE2;
                                S_PAUSE2: begin
                                    cyc_d   = cycDec;
                                    state_d = (cycDec == '0) ? S_DRAIN : S_FWD;
                                end
                                S_DRAIN: begin
                                    if (mode_q == MODE_FULL && !pass_q) begin
                                        pass_d  = 1'b1;
                                        cyc_d   = RINSE_LD;
                                        state_d = S_FILL;
                                    end else if (mode_q == MODE_FULL || mode_q == MODE_SPIN) begin
                                        state_d = S_SPIN;
                                    end else begin
                                        state_d = S_DONE;
                                    end
                                end
                                S_SPIN:   state_d = S_DONE;
                                default:  state_d = S_IDLE;
                            endcase
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode: a pure function of the state register and the cycle count.
    always_comb begin
        motor_fwd = 1'b0;
        motor_rev = 1'b0;
        inlet     = 1'b0;
        drain     = 1'b0;
        spin      = 1'b0;
        led_stop  = 1'b0;
        alarm     = 1'b0;
        busy      = 1'b0;
        phase     = state_q;
        cyc_left  = cyc_q;
        case (state_q)
            S_IDLE:   led_stop = 1'b1;
            S_FILL: begin
                inlet = 1'b1;
                busy  = 1'b1;
            end
            S_FWD: begin
                motor_fwd = 1'b1;
                busy      = 1'b1;
            end
            S_PAUSE1, S_PAUSE2: begin
                led_stop = 1'b1;
                busy     = 1'b1;
            end
            S_REV: begin
                motor_rev = 1'b1;
                busy      = 1'b1;
            end
            S_DRAIN: begin
                drain = 1'b1;
                busy  = 1'b1;
            end
            S_SPIN: begin
                spin  = 1'b1;
                drain = 1'b1;
                busy  = 1'b1;
            end
            S_DONE, S_ESTOP: begin
                led_stop = 1'b1;
                alarm    = 1'b1;
            end
            default: led_stop = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_washer_prog_seq.sv
// Testbench for washer_prog_seq: directed program runs followed by random panel activity,
// each cycle compared against a schedule-based reference model of the programs.
module tb_washer_prog_seq;

    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 8;
    localparam int CYC_W     = 4;
    localparam int FILL_SEC  = 2;
    localparam int RUN_SEC   = 3;
    localparam int PAUSE_SEC = 1;
    localparam int DRAIN_SEC = 2;
    localparam int SPIN_SEC  = 3;
    localparam int WASH_CYC  = 2;
    localparam int RINSE_CYC = 1;

    localparam logic [3:0] P_IDLE  = 4'd0, P_FILL = 4'd1, P_FWD   = 4'd2, P_PAUSE1 = 4'd3;
    localparam logic [3:0] P_REV   = 4'd4, P_PAUSE2 = 4'd5, P_DRAIN = 4'd6, P_SPIN  = 4'd7;
    localparam logic [3:0] P_DONE  = 4'd8, P_ESTOP = 4'd9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode_sel = 2'd0;
    logic             estop = 1'b0;
    logic             motor_fwd, motor_rev, inlet, drain, spin, led_stop, alarm, busy;
    logic [3:0]       phase;
    logic [CYC_W-1:0] cyc_left;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of upcoming phases, each with its length in clocks and cycle count.
    typedef struct {
        logic [3:0] ph;
        int         dur;
        int         cyc;
    } seg_t;

    seg_t       segQ[$];
    logic [3:0] mPhase = P_IDLE;
    int         mRemain = 0;
    int         mCyc = 0;
    logic       mPrev = 1'b0;

    washer_prog_seq #(
        .TICK_DIV (TICK_DIV),  .CNT_W    (CNT_W),     .CYC_W    (CYC_W),
        .FILL_SEC (FILL_SEC),  .RUN_SEC  (RUN_SEC),   .PAUSE_SEC(PAUSE_SEC),
        .DRAIN_SEC(DRAIN_SEC), .SPIN_SEC (SPIN_SEC),  .WASH_CYC (WASH_CYC),
        .RINSE_CYC(RINSE_CYC)
    ) dut (
        .clk      (clk),       .rst      (rst),       .start    (start),
        .mode_sel (mode_sel),  .estop    (estop),     .motor_fwd(motor_fwd),
        .motor_rev(motor_rev), .inlet    (inlet),     .drain    (drain),
        .spin     (spin),      .led_stop (led_stop),  .alarm    (alarm),
        .busy     (busy),      .phase    (phase),     .cyc_left (cyc_left)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic void pushSeg(input logic [3:0] ph, input int sec, input int cyc);
        seg_t s;
        s.ph  = ph;
        s.dur = sec * TICK_DIV;
        s.cyc = cyc;
        segQ.push_back(s);
    endfunction

    function automatic void pushPass(input int ncyc);
        pushSeg(P_FILL, FILL_SEC, ncyc);
        for (int k = ncyc; k >= 1; k--) begin
            pushSeg(P_FWD,    RUN_SEC,   k);
            pushSeg(P_PAUSE1, PAUSE_SEC, k);
            pushSeg(P_REV,    RUN_SEC,   k);
            pushSeg(P_PAUSE2, PAUSE_SEC, k);
        end
        pushSeg(P_DRAIN, DRAIN_SEC, 0);
    endfunction

    function automatic void buildSchedule(input logic [1:0] m);
        segQ.delete();
        case (m)
            2'd0: pushPass(WASH_CYC);
            2'd1: pushPass(RINSE_CYC);
            2'd2: begin
                pushPass(WASH_CYC);
                pushPass(RINSE_CYC);
                pushSeg(P_SPIN, SPIN_SEC, 0);
            end
            default: begin
                pushSeg(P_DRAIN, DRAIN_SEC, WASH_CYC);
                pushSeg(P_SPIN,  SPIN_SEC,  WASH_CYC);
            end
        endcase
    endfunction

    function automatic void loadNext();
        seg_t s;
        if (segQ.size() > 0) begin
            s       = segQ.pop_front();
            mPhase  = s.ph;
            mRemain = s.dur;
            mCyc    = s.cyc;
        end else begin
            mPhase = P_DONE;
        end
    endfunction

    // Expected {fwd,rev,inlet,drain,spin,led_stop,alarm,busy} for a phase.
    function automatic logic [7:0] expOut(input logic [3:0] ph);
        case (ph)
            P_FILL:             return 8'b0010_0001;
            P_FWD:              return 8'b1000_0001;
            P_REV:              return 8'b0100_0001;
            P_PAUSE1, P_PAUSE2: return 8'b0000_0101;
            P_DRAIN:            return 8'b0001_0001;
            P_SPIN:             return 8'b0001_1001;
            P_DONE, P_ESTOP:    return 8'b0000_0110;
            default:            return 8'b0000_0100;
        endcase
    endfunction

    function automatic void modelStep(input logic st, input logic [1:0] ms, input logic es, input logic rs);
        logic edgeSeen;
        edgeSeen = st && !mPrev;
        if (rs) begin
            mPhase = P_IDLE;
            mCyc   = 0;
            segQ.delete();
            mPrev  = 1'b0;
        end else begin
            if (es && mPhase != P_IDLE) begin
                mPhase = P_ESTOP;
                mCyc   = 0;
                segQ.delete();
            end else if ((mPhase == P_IDLE || mPhase == P_DONE) && edgeSeen && !es) begin
                buildSchedule(ms);
                loadNext();
            end else if (mPhase == P_ESTOP) begin
                if (!es && !st) mPhase = P_IDLE;
            end else if (mPhase >= P_FILL && mPhase <= P_SPIN) begin
                mRemain--;
                if (mRemain == 0) loadNext();
            end
            mPrev = st;
        end
    endfunction

    task automatic checkOutput();
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {motor_fwd, motor_rev, inlet, drain, spin, led_stop, alarm, busy};
        exp = expOut(mPhase);
        checks++;
        assert (phase === mPhase) else begin
            errors++;
            $error("[TB] FAIL phase: observed %0d expected %0d at %0t", phase, mPhase, $time);
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL outputs: observed %b expected %b (phase %0d) at %0t", obs, exp, mPhase, $time);
        end
        checks++;
        assert (cyc_left === CYC_W'(mCyc)) else begin
            errors++;
            $error("[TB] FAIL cyc_left: observed %0d expected %0d at %0t", cyc_left, mCyc, $time);
        end
        checks++;
        assert (!(motor_fwd && motor_rev) && !(inlet && drain)) else begin
            errors++;
            $error("[TB] FAIL interlock: observed fwd=%b rev=%b inlet=%b drain=%b expected no overlap", motor_fwd, motor_rev, inlet, drain);
        end
    endtask

    // Drive one cycle of panel inputs, advance the model on the edge, then compare.
    task automatic applyStimulus(input logic st, input logic [1:0] ms, input logic es, input logic rs);
        @(negedge clk);
        start    = st;
        mode_sel = ms;
        estop    = es;
        rst      = rs;
        @(posedge clk);
        modelStep(st, ms, es, rs);
        #1;
        checkOutput();
    endtask

    task automatic runUntil(input logic [3:0] target, input logic st, input logic [1:0] ms,
                            input int limit, output int n);
        n = 0;
        while (phase !== target && n < limit) begin
            applyStimulus(st, ms, 1'b0, 1'b0);
            n++;
        end
        checks++;
        assert (phase === target) else begin
            errors++;
            $error("[TB] FAIL wait_phase: observed %0d expected %0d within %0d cycles", phase, target, limit);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int estopHold;
        logic st;
        logic [1:0] ms;

        // Reset state.
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        // Mode 0: accepted edge enters FILL, DONE 80 clocks after FILL entry.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        checkCount("mode0_fill_entry", int'(phase), int'(P_FILL));
        runUntil(P_DONE, 1'b1, 2'd0, 200, n);
        checkCount("mode0_duration", n, 80);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        // Mode 2 straight from DONE: 140 clocks.
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        runUntil(P_DONE, 1'b0, 2'd0, 300, n);
        checkCount("mode2_duration", n, 140);

        // Mode 3: DRAIN then SPIN, 20 clocks.
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        checkCount("mode3_drain_entry", int'(phase), int'(P_DRAIN));
        runUntil(P_DONE, 1'b0, 2'd1, 100, n);
        checkCount("mode3_duration", n, 20);

        // E-stop mid-REV, held start blocks the return to IDLE.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        runUntil(P_REV, 1'b0, 2'd0, 100, n);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        checkCount("estop_entry", int'(phase), int'(P_ESTOP));
        checkCount("estop_rev_off", int'(motor_rev), 0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        checkCount("estop_start_held", int'(phase), int'(P_ESTOP));
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkCount("estop_release", int'(phase), int'(P_IDLE));

        // E-stop in IDLE blocks a start edge.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        checkCount("idle_estop_block", int'(phase), int'(P_IDLE));
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        // Start toggles and mode_sel changes while running are ignored.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        n = 0;
        while (phase !== P_DONE && n < 200) begin
            applyStimulus(n < 6 ? n[0] : 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            n++;
        end
        checkCount("ignore_inputs_duration", n, 80);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        // Reset mid-FWD.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        runUntil(P_FWD, 1'b1, 2'd1, 100, n);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
        checkCount("rst_mid_fwd", int'(phase), int'(P_IDLE));
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

        // Random panel activity against the model.
        st        = 1'b0;
        ms        = 2'd0;
        estopHold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) st = ~st;
            if ($urandom_range(0, 7) == 0) ms = 2'($urandom_range(0, 3));
            if (estopHold == 0 && $urandom_range(0, 249) == 0) estopHold = $urandom_range(1, 6);
            applyStimulus(st, ms, estopHold != 0, $urandom_range(0, 599) == 0);
            if (estopHold != 0) estopHold--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
